// File: rtl/mod_inverse_if.sv
// mod_inverse_if: start/done handshake and operand/result bundle for mod_inverse_engine
// Ports (master drives): start_i, a_i, n_i (abort_i when MODINV_ABORT_EN is defined)
// Ports (slave drives):  ready_o, done_o, inv_o, error_o
interface mod_inverse_if #(parameter int WORD_WIDTH = 32) ();
  logic                  start_i;
  logic [WORD_WIDTH-1:0] a_i;
  logic [WORD_WIDTH-1:0] n_i;
`ifdef MODINV_ABORT_EN
  logic                  abort_i;
`endif
  logic                  ready_o;
  logic                  done_o;
  logic [WORD_WIDTH-1:0] inv_o;
  logic                  error_o;
`ifdef MODINV_ABORT_EN
  modport master (output start_i, a_i, n_i, abort_i, input ready_o, done_o, inv_o, error_o);
  modport slave (input start_i, a_i, n_i, abort_i, output ready_o, done_o, inv_o, error_o);
`else
  modport master (output start_i, a_i, n_i, input ready_o, done_o, inv_o, error_o);
  modport slave (input start_i, a_i, n_i, output ready_o, done_o, inv_o, error_o);
`endif
endinterface

// File: rtl/mod_inverse_engine.sv
// mod_inverse_engine: sequential extended-Euclid modular inverse with bit-serial restoring divider
// Ports: clk, rst_n (sync active-low), bus (mod_inverse_if.slave: start_i/a_i/n_i in,
//        ready_o/done_o/inv_o/error_o out). Optional MODINV_ABORT_EN adds bus.abort_i.
module mod_inverse_engine #(
  parameter int WORD_WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  mod_inverse_if.slave  bus
);
  localparam int W  = WORD_WIDTH;
  localparam int CW = $clog2(W);
  typedef enum logic [2:0] {IDLE, INIT, CHECK, DIV, UPDATE, FINAL} state_t;
  state_t                r_state;
  logic [W-1:0]          r_a, r_n, r_r0, r_r1, r_q, r_rem, r_inv;
  logic signed [W+1:0]   r_t0, r_t1;
  logic [CW-1:0]         r_cnt;
  logic                  r_ready, r_done, r_error;
  logic [W:0]            w_shift;
  logic                  w_ge;
  logic [W-1:0]          w_diff, w_inv;
  logic signed [W+1:0]   w_prod, w_t_new;
  logic                  w_abort;
  // Partial remainder never exceeds r1, so the W-bit difference is exact.
  always_comb begin
    w_shift = {r_rem, r_r0[r_cnt]};
    w_ge    = w_shift >= {1'b0, r_r1};
    w_diff  = w_shift[W-1:0] - r_r1;
    w_prod  = $signed({2'b00, r_q}) * r_t1;
    w_t_new = r_t0 - w_prod;
    w_inv   = r_t0[W+1] ? W'(r_t0 + $signed({2'b00, r_n})) : r_t0[W-1:0];
  end
`ifdef MODINV_ABORT_EN
  assign w_abort = bus.abort_i;
`else
  assign w_abort = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_n     <= '0;
      r_r0    <= '0;
      r_r1    <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_inv   <= '0;
      r_t0    <= '0;
      r_t1    <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else if (r_state != IDLE && w_abort) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.start_i) begin
          r_a     <= bus.a_i;
          r_n     <= bus.n_i;
          r_ready <= 1'b0;
          r_state <= INIT;
        end
        INIT: if (r_n < W'(2)) begin
          r_error <= 1'b1;
          r_inv   <= '0;
          r_done  <= 1'b1;
          r_state <= FINAL;
        end else begin
          r_r0    <= r_n;
          r_r1    <= r_a;
          r_t0    <= '0;
          r_t1    <= {{(W+1){1'b0}}, 1'b1};
          r_state <= CHECK;
        end
        CHECK: if (r_r1 == '0) begin
          r_error <= r_r0 != W'(1);
          r_inv   <= r_r0 != W'(1) ? '0 : w_inv;
          r_done  <= 1'b1;
          r_state <= FINAL;
        end else begin
          r_rem   <= '0;
          r_q     <= '0;
          r_cnt   <= CW'(W - 1);
          r_state <= DIV;
        end
        DIV: begin
          r_rem   <= w_ge ? w_diff : w_shift[W-1:0];
          r_q     <= {r_q[W-2:0], w_ge};
          r_cnt   <= r_cnt - 1'b1;
          r_state <= r_cnt == '0 ? UPDATE : DIV;
        end
        UPDATE: begin
          r_r0    <= r_r1;
          r_r1    <= r_rem;
          r_t0    <= r_t1;
          r_t1    <= w_t_new;
          r_state <= CHECK;
        end
        FINAL: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.ready_o = r_ready;
  assign bus.done_o  = r_done;
  assign bus.inv_o   = r_inv;
  assign bus.error_o = r_error;
endmodule

// File: tb/tb_mod_inverse_engine.sv
// tb_mod_inverse_engine: directed and random checks of mod_inverse_engine against an Euclid reference
module tb_mod_inverse_engine;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int errs = 0;
  mod_inverse_if #(.WORD_WIDTH(W)) bus ();
  mod_inverse_engine #(.WORD_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Textbook extended Euclid on integers; k counts division steps, -1 for a degenerate modulus.
  function automatic void ref_model(input longint a, input longint n, output logic err,
                                    output longint inv, output int k);
    longint r0, r1, t0, t1, q, tmp;
    k = 0;
    if (n < 2) begin
      err = 1'b1;
      inv = 0;
      k = -1;
      return;
    end
    r0 = n; r1 = a; t0 = 0; t1 = 1;
    while (r1 != 0) begin
      q = r0 / r1;
      tmp = r0 % r1; r0 = r1; r1 = tmp;
      tmp = t0 - q * t1; t0 = t1; t1 = tmp;
      k++;
    end
    err = r0 != 1;
    inv = err ? 0 : (t0 < 0 ? t0 + n : t0);
  endfunction
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] n, input bit hold, input string tag);
    logic e_err;
    longint e_inv;
    int k, lat, c;
    bit got, ready_bad;
    logic [63:0] prod;
    ref_model(longint'(a), longint'(n), e_err, e_inv, k);
    lat = k < 0 ? 2 : 3 + k * (W + 2);
    @(negedge clk);
    chk({tag, " idle_ready"}, 64'(bus.ready_o), 64'd1);
    bus.start_i = 1'b1;
    bus.a_i = a;
    bus.n_i = n;
    @(negedge clk);
    c = 1;
    if (hold) begin
      bus.a_i = a + 32'd5;
      bus.n_i = n ^ 32'h55;
    end else bus.start_i = 1'b0;
    got = 0;
    ready_bad = 0;
    while (!got && c < 5000) begin
      if (bus.ready_o !== 1'b0) ready_bad = 1;
      if (bus.done_o === 1'b1) got = 1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    bus.start_i = 1'b0;
    chk({tag, " done_seen"}, 64'(got), 64'd1);
    chk({tag, " latency"}, 64'(c), 64'(lat));
    chk({tag, " busy_ready_low"}, 64'(ready_bad), 64'd0);
    chk({tag, " inv"}, 64'(bus.inv_o), 64'(e_inv));
    chk({tag, " error"}, 64'(bus.error_o), 64'(e_err));
    if (!e_err) begin
      prod = (64'(a) * 64'(bus.inv_o)) % 64'(n);
      chk({tag, " a_times_inv"}, prod, 64'd1);
    end
    @(negedge clk);
    chk({tag, " ready_after"}, 64'(bus.ready_o), 64'd1);
    chk({tag, " done_after"}, 64'(bus.done_o), 64'd0);
  endtask
  initial begin
    int seen;
    logic [W-1:0] ra, rn;
    bus.start_i = 1'b0;
    bus.a_i = '0;
    bus.n_i = '0;
`ifdef MODINV_ABORT_EN
    bus.abort_i = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ready", 64'(bus.ready_o), 64'd1);
    chk("rst done", 64'(bus.done_o), 64'd0);
    chk("rst inv", 64'(bus.inv_o), 64'd0);
    chk("rst error", 64'(bus.error_o), 64'd0);
    rst_n = 1'b1;
    run_op(32'd3, 32'd7, 1'b0, "basic");
    run_op(32'd17, 32'd3120, 1'b0, "rsa");
    run_op(32'd3120, 32'd17, 1'b0, "rsa_swap");
    run_op(32'd6, 32'd9, 1'b0, "noinv");
    run_op(32'd0, 32'd7, 1'b0, "a_zero");
    run_op(32'd5, 32'd1, 1'b0, "n_one");
    run_op(32'd5, 32'd0, 1'b0, "n_zero");
    run_op(32'd1, 32'd2, 1'b0, "n_two");
    run_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, "max");
    run_op(32'd3, 32'd7, 1'b1, "hold_start");
    // Reset in the middle of a division: outputs return to reset values, no done pulse.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.a_i = 32'd17;
    bus.n_i = 32'd3120;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst ready", 64'(bus.ready_o), 64'd1);
    chk("midrst done", 64'(bus.done_o), 64'd0);
    chk("midrst inv", 64'(bus.inv_o), 64'd0);
    chk("midrst error", 64'(bus.error_o), 64'd0);
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) seen++;
    end
    chk("midrst no_done", 64'(seen), 64'd0);
`ifdef MODINV_ABORT_EN
    run_op(32'd3, 32'd7, 1'b0, "pre_abort");
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.a_i = 32'd17;
    bus.n_i = 32'd3120;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (8) @(negedge clk);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    chk("abort ready", 64'(bus.ready_o), 64'd1);
    chk("abort inv_kept", 64'(bus.inv_o), 64'd5);
    chk("abort error_kept", 64'(bus.error_o), 64'd0);
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) seen++;
    end
    chk("abort no_done", 64'(seen), 64'd0);
`endif
    for (int i = 0; i < 20; i++) begin
      rn = (i % 2 == 0) ? $urandom : W'($urandom_range(2, 5000));
      ra = (i % 5 == 0) ? rn + W'($urandom_range(1, 100)) : $urandom;
      run_op(ra, rn, 1'b0, "random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
